rsa_port_responder: RTL
=======================

Name: rsa_port_responder

Overview:
- Responder end of the host/accelerator port protocol that the hardware-eval stimulus wrapper drives as initiator.
- Accepts 32-bit commands on port1 and 512-bit operands on bram_din1/2, then launches the Montgomery core through a start/done interface.
- Presents results on bram_dout1/2 and reports completion plus a status word on port2.
- Sits between the host-facing ports and the compute core inside the accelerator wrapper.

Parameters:
WORD_LEN, 512, operand/result width
TIMEOUT_CYCLES, 65535, maximum cycles in RUN before abort (must be >= 1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
port1_din  in  32  command word, opcode in [3:0], other bits ignored
port1_valid  in  1  command present, level held by initiator until port1_read seen
port1_read  out  1  one-cycle command-accept pulse
bram_din1  in  WORD_LEN  operand A
bram_din2  in  WORD_LEN  operand B
bram_din_valid  in  1  operands valid
bram_dout1  out  WORD_LEN  result 1
bram_dout2  out  WORD_LEN  result 2
bram_dout1_valid  out  1  result 1 presented
bram_dout2_valid  out  1  result 2 presented
bram_dout_read  in  1  host consumed results
port2_dout  out  32  status word
port2_valid  out  1  command complete, status valid
port2_read  in  1  host acknowledged status
core_start  out  1  one-cycle core launch pulse
core_op_a  out  WORD_LEN  latched operand A
core_op_b  out  WORD_LEN  latched operand B
core_done  in  1  core finished, results valid this cycle
core_res1  in  WORD_LEN  core result 1
core_res2  in  WORD_LEN  core result 2
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (resetn=0, asynchronous): all outputs, operand/result registers, result_valid flag and counter go to 0; state = IDLE. Reset mid-operation aborts with no status emitted.
- All outputs registered.
- Opcodes: 1 LOAD, 2 START, 3 READ, 4 CLR. Any other value is BAD_OPCODE.
- Status word: [31:28] opcode, [27:24] code (0 OK, 1 BAD_OPCODE, 2 TIMEOUT, 3 NO_RESULT), [23:16] 0, [15:0] RUN cycle count (saturating at 0xFFFF; 0 for non-START commands).
- IDLE: when port1_valid is sampled high, latch opcode, pulse port1_read next cycle, go to DECODE. port1_valid outside IDLE is ignored, and port1_read stays 0.
- DECODE (1 cycle):
  - LOAD -> LOAD.
  - START -> RUN, pulsing core_start and clearing the counter.
  - READ -> OUT if result_valid, else STATUS with code 3.
  - CLR -> clear operands, results and result_valid, then STATUS with code 0.
  - Other opcode -> STATUS with code 1.
- LOAD: wait for bram_din_valid; capture bram_din1/2 into core_op_a/b; go to STATUS with code 0. bram_din_valid outside LOAD is ignored.
- RUN: the counter increments every cycle in RUN, including the cycle core_done is sampled.
  - core_done high: capture core_res1/2, set result_valid, go to STATUS with code 0.
  - Counter reaches TIMEOUT_CYCLES without done: STATUS with code 2; result_valid is unchanged.
  - If done and timeout coincide, done wins.
- OUT: bram_dout1_valid and bram_dout2_valid are high together and bram_dout1/2 hold the results. When bram_dout_read is sampled high, drop both valids next cycle and go to STATUS with code 0. result_valid stays set, so READ can be repeated.
- STATUS: port2_valid is high with port2_dout stable until port2_read is sampled high. port2_valid drops the next cycle, and the state returns to IDLE. Unlimited backpressure is allowed.
- core_done outside RUN is ignored.

Decomposition:
- Shared package rsa_port_pkg: opcode constants, status code constants, state encoding, status word field positions.
- One natural sub-module, rsa_run_timer: saturating 16-bit cycle counter with timeout compare (inputs clear/enable, outputs count/expired).

Test Plan:
- Reset: resetn low mid-RUN (after 5 cycles) -> all outputs 0 immediately; busy=0; a following READ returns 0x33000000.
- LOAD: send 0x1 with bram_din1=0xFF0000, bram_din2=0x3 -> one port1_read pulse; core_op_a=0xFF0000, core_op_b=0x3; status 0x10000000.
- START: bench core asserts core_done in the 10th RUN cycle with res1=0xABC, res2=0x1 -> exactly one core_start pulse; status 0x2000000A; then READ 0x3 -> bram_dout1=0xABC, both dout valids high until bram_dout_read; status 0x30000000.
- Timeout: TIMEOUT_CYCLES=20, core_done never asserted -> status 0x22000014; a subsequent READ with no prior success returns 0x33000000.
- Bad opcode 0x7 -> status 0x71000000; then CLR 0x4 -> status 0x40000000 and core_op_a=0.
- Backpressure and protocol: port2_read held low for 50 cycles -> port2_valid and port2_dout stable throughout; port1_valid raised while busy -> no port1_read until the state returns to IDLE.

Source files
------------

// File: rtl/rsa_port_pkg.sv
// Shared definitions for the RSA host-port responder: opcodes, status codes,
// FSM state encoding and status word layout.
`timescale 1ns / 1ps
package rsa_port_pkg;

   localparam logic [3:0] OpLoad  = 4'd1;
   localparam logic [3:0] OpStart = 4'd2;
   localparam logic [3:0] OpRead  = 4'd3;
   localparam logic [3:0] OpClr   = 4'd4;

   localparam logic [3:0] CodeOk        = 4'd0;
   localparam logic [3:0] CodeBadOpcode = 4'd1;
   localparam logic [3:0] CodeTimeout   = 4'd2;
   localparam logic [3:0] CodeNoResult  = 4'd3;

   localparam int unsigned StatusOpLsb    = 28;
   localparam int unsigned StatusCodeLsb  = 24;
   localparam int unsigned StatusCountLsb = 0;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StLoad,
      StRun,
      StOut,
      StStatus
   } state_e;

   // Pack opcode, completion code and RUN cycle count; bits [23:16] stay zero.
   function automatic logic [31:0] make_status(input logic [3:0]  op,
                                                input logic [3:0]  code,
                                                input logic [15:0] count);
      logic [31:0] word;
      word = '0;
      word[StatusOpLsb +: 4]     = op;
      word[StatusCodeLsb +: 4]   = code;
      word[StatusCountLsb +: 16] = count;
      return word;
   endfunction

endpackage

// File: rtl/rsa_port_responder_timer.sv
// Saturating 16-bit RUN cycle counter with timeout compare.
// count/expired reflect the value the counter holds after this cycle's
// increment, so the FSM can report and react in the same cycle.
`timescale 1ns / 1ps
module rsa_run_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clear,
   input  logic        enable,
   output logic [15:0] count,
   output logic        expired
);

   logic [15:0] count_q, count_d;

   // Next count: clear wins, otherwise increment while enabled, saturating.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_d;
   assign expired = enable && (32'(count_d) >= TIMEOUT_CYCLES);

endmodule

// File: rtl/rsa_port_responder.sv
// Responder end of the host/accelerator port: takes commands on port1,
// operands on bram_din, runs the Montgomery core and reports on port2.
`timescale 1ns / 1ps
module rsa_port_responder
   import rsa_port_pkg::*;
#(
   parameter int unsigned WORD_LEN       = 512,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [31:0]         port1_din,
   input  logic                port1_valid,
   output logic                port1_read,
   input  logic [WORD_LEN-1:0] bram_din1,
   input  logic [WORD_LEN-1:0] bram_din2,
   input  logic                bram_din_valid,
   output logic [WORD_LEN-1:0] bram_dout1,
   output logic [WORD_LEN-1:0] bram_dout2,
   output logic                bram_dout1_valid,
   output logic                bram_dout2_valid,
   input  logic                bram_dout_read,
   output logic [31:0]         port2_dout,
   output logic                port2_valid,
   input  logic                port2_read,
   output logic                core_start,
   output logic [WORD_LEN-1:0] core_op_a,
   output logic [WORD_LEN-1:0] core_op_b,
   input  logic                core_done,
   input  logic [WORD_LEN-1:0] core_res1,
   input  logic [WORD_LEN-1:0] core_res2,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [WORD_LEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [WORD_LEN-1:0] res1_q, res1_d, res2_q, res2_d;
   logic                res_valid_q, res_valid_d;
   logic                port1_read_q, port1_read_d;
   logic                core_start_q, core_start_d;
   logic                dout_valid_q, dout_valid_d;
   logic                port2_valid_q, port2_valid_d;
   logic [31:0]         port2_dout_q, port2_dout_d;
   logic                busy_q;
   logic [15:0]         run_count;
   logic                run_expired;
   logic                unused_din;

   // Only the opcode nibble of the command word is meaningful.
   assign unused_din = ^port1_din[31:4];

   rsa_run_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .resetn (resetn),
      .clear  (state_q == StDecode),
      .enable (state_q == StRun),
      .count  (run_count),
      .expired(run_expired)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      res1_d        = res1_q;
      res2_d        = res2_q;
      res_valid_d   = res_valid_q;
      port1_read_d  = 1'b0;
      core_start_d  = 1'b0;
      dout_valid_d  = dout_valid_q;
      port2_valid_d = port2_valid_q;
      port2_dout_d  = port2_dout_q;

      case (state_q)
         StIdle: begin
            if (port1_valid) begin
               opcode_d     = port1_din[3:0];
               port1_read_d = 1'b1;
               state_d      = StDecode;
            end
         end
         StDecode: begin
            case (opcode_q)
               OpLoad: state_d = StLoad;
               OpStart: begin
                  core_start_d = 1'b1;
                  state_d      = StRun;
               end
               OpRead: begin
                  if (res_valid_q) begin
                     dout_valid_d = 1'b1;
                     state_d      = StOut;
                  end else begin
                     port2_dout_d  = make_status(opcode_q, CodeNoResult, 16'h0);
                     port2_valid_d = 1'b1;
                     state_d       = StStatus;
                  end
               end
               OpClr: begin
                  op_a_d        = '0;
                  op_b_d        = '0;
                  res1_d        = '0;
                  res2_d        = '0;
                  res_valid_d   = 1'b0;
                  port2_dout_d  = make_status(opcode_q, CodeOk, 16'h0);
                  port2_valid_d = 1'b1;
                  state_d       = StStatus;
               end
               default: begin
                  port2_dout_d  = make_status(opcode_q, CodeBadOpcode, 16'h0);
                  port2_valid_d = 1'b1;
                  state_d       = StStatus;
               end
            endcase
         end
         StLoad: begin
            if (bram_din_valid) begin
               op_a_d        = bram_din1;
               op_b_d        = bram_din2;
               port2_dout_d  = make_status(opcode_q, CodeOk, 16'h0);
               port2_valid_d = 1'b1;
               state_d       = StStatus;
            end
         end
         StRun: begin
            // Done takes priority over a coincident timeout.
            if (core_done) begin
               res1_d        = core_res1;
               res2_d        = core_res2;
               res_valid_d   = 1'b1;
               port2_dout_d  = make_status(opcode_q, CodeOk, run_count);
               port2_valid_d = 1'b1;
               state_d       = StStatus;
            end else if (run_expired) begin
               port2_dout_d  = make_status(opcode_q, CodeTimeout, run_count);
               port2_valid_d = 1'b1;
               state_d       = StStatus;
            end
         end
         StOut: begin
            if (bram_dout_read) begin
               dout_valid_d  = 1'b0;
               port2_dout_d  = make_status(opcode_q, CodeOk, 16'h0);
               port2_valid_d = 1'b1;
               state_d       = StStatus;
            end
         end
         StStatus: begin
            if (port2_read) begin
               port2_valid_d = 1'b0;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any operation silently.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         opcode_q      <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         res1_q        <= '0;
         res2_q        <= '0;
         res_valid_q   <= 1'b0;
         port1_read_q  <= 1'b0;
         core_start_q  <= 1'b0;
         dout_valid_q  <= 1'b0;
         port2_valid_q <= 1'b0;
         port2_dout_q  <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         res1_q        <= res1_d;
         res2_q        <= res2_d;
         res_valid_q   <= res_valid_d;
         port1_read_q  <= port1_read_d;
         core_start_q  <= core_start_d;
         dout_valid_q  <= dout_valid_d;
         port2_valid_q <= port2_valid_d;
         port2_dout_q  <= port2_dout_d;
         busy_q        <= (state_d != StIdle);
      end
   end

   assign port1_read       = port1_read_q;
   assign core_start       = core_start_q;
   assign core_op_a        = op_a_q;
   assign core_op_b        = op_b_q;
   assign bram_dout1       = res1_q;
   assign bram_dout2       = res2_q;
   assign bram_dout1_valid = dout_valid_q;
   assign bram_dout2_valid = dout_valid_q;
   assign port2_dout       = port2_dout_q;
   assign port2_valid      = port2_valid_q;
   assign busy             = busy_q;

endmodule
